// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: IDLE/PLAY/DIE/RESTART FSM, movement tick,
// collision detection and single-shot apple length/score increments.
module snake_game_ctrl #(
    parameter int TICK_DIV  = 250000,
    parameter int DIE_TICKS = 16,
    parameter int MAX_LEN   = 16,
    parameter int X_MAX     = 38,
    parameter int Y_MAX     = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic [5:0] head_x,
    input  logic [4:0] head_y,
    input  logic       hit_body,
    input  logic       add_cube,
    output logic [1:0] game_state,
    output logic       move_tick,
    output logic [4:0] body_len,
    output logic [7:0] score,
    output logic       flash,
    output logic       restart
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_PLAY    = 2'b01,
        S_DIE     = 2'b10,
        S_RESTART = 2'b11
    } state_t;

    localparam logic [27:0] TICK_LAST = 28'(TICK_DIV - 1);
    localparam logic [4:0]  DIE_LAST  = 5'(DIE_TICKS - 1);
    localparam logic [4:0]  LEN_MAX   = 5'(MAX_LEN);
    localparam logic [4:0]  LEN_INIT  = 5'd3;
    localparam logic [5:0]  X_LIM     = 6'(X_MAX);
    localparam logic [4:0]  Y_LIM     = 5'(Y_MAX);

    state_t      state_q, state_d;
    logic [27:0] cnt_q, cnt_d;
    logic [4:0]  die_q, die_d;
    logic [4:0]  len_q, len_d;
    logic [7:0]  score_q, score_d;
    logic        flash_q, flash_d;
    logic        move_q, move_d;
    logic        restart_q, restart_d;
    logic        key_prev_q, add_prev_q;

    logic start_edge, eat_edge, tick, collide;

    assign start_edge = key_start & ~key_prev_q;
    assign eat_edge   = add_cube & ~add_prev_q;
    assign tick       = (cnt_q == TICK_LAST);
    assign collide    = (head_x == 6'd0) | (head_x > X_LIM) |
                        (head_y == 5'd0) | (head_y > Y_LIM) | hit_body;

    always_comb begin
        state_d   = state_q;
        die_d     = die_q;
        len_d     = len_q;
        score_d   = score_q;
        flash_d   = flash_q;
        move_d    = 1'b0;
        cnt_d     = 28'd0;
        unique case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d = S_PLAY;
                    len_d   = LEN_INIT;
                    score_d = 8'd0;
                end
            end
            S_PLAY: begin
                if (collide) begin
                    state_d = S_DIE;
                end else begin
                    move_d = tick;
                    if (eat_edge) begin
                        if (len_q < LEN_MAX) len_d = len_q + 5'd1;
                        if (score_q != 8'hFF) score_d = score_q + 8'd1;
                    end
                end
            end
            S_DIE: begin
                if (tick) begin
                    if (die_q == DIE_LAST) begin
                        state_d = S_RESTART;
                        flash_d = 1'b0;
                    end else begin
                        die_d   = die_q + 5'd1;
                        flash_d = ~flash_q;
                    end
                end
            end
            S_RESTART: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        // Counter and die count restart from zero on every state entry
        if (state_d != state_q) begin
            die_d = 5'd0;
        end else if ((state_q == S_PLAY || state_q == S_DIE) && !tick) begin
            cnt_d = cnt_q + 28'd1;
        end
        restart_d = (state_d == S_RESTART);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 28'd0;
            die_q      <= 5'd0;
            len_q      <= LEN_INIT;
            score_q    <= 8'd0;
            flash_q    <= 1'b0;
            move_q     <= 1'b0;
            restart_q  <= 1'b0;
            key_prev_q <= 1'b0;
            add_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            die_q      <= die_d;
            len_q      <= len_d;
            score_q    <= score_d;
            flash_q    <= flash_d;
            move_q     <= move_d;
            restart_q  <= restart_d;
            key_prev_q <= key_start;
            add_prev_q <= add_cube;
        end
    end

    assign game_state = state_q;
    assign move_tick  = move_q;
    assign body_len   = len_q;
    assign score      = score_q;
    assign flash      = flash_q;
    assign restart    = restart_q;

endmodule
